// File: rtl/reg_readback_pkg.sv
// reg_readback_pkg: shared state encoding, default widths and frame-length helper
package reg_readback_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam int W1_DEF = 4;
    localparam int W2_DEF = 2;

    function automatic int frame_len(input int w1, input int w2, input bit par);
        return w1 + w2 + int'(par);
    endfunction

endpackage

// File: rtl/reg_readback_serializer_if.sv
// reg_readback_serializer_if: request/capture inputs and serial link outputs of the readback path
interface reg_readback_serializer_if #(
    parameter int W1 = 4,
    parameter int W2 = 2
);
    logic          rd_req;
    logic [W1-1:0] rd_q1;
    logic [W2-1:0] rd_q2;
    logic          ser_ready;
    logic          ser_valid;
    logic          ser_data;
    logic          ser_last;
    logic          busy;
    logic          done;

    modport master (
        output rd_req, rd_q1, rd_q2, ser_ready,
        input  ser_valid, ser_data, ser_last, busy, done
    );

    modport slave (
        input  rd_req, rd_q1, rd_q2, ser_ready,
        output ser_valid, ser_data, ser_last, busy, done
    );
endinterface

// File: rtl/reg_readback_shifter.sv
// reg_readback_shifter: snapshot register that shifts toward the bit being sent
module reg_readback_shifter #(
    parameter int N = 6
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic         advance,
    input  logic         msb_first,
    input  logic [N-1:0] din,
    output logic         dout
);
    logic [N-1:0] snap;

    // capture on load, shift the sent bit out on each accepted handshake
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            snap <= '0;
        else if (load)
            snap <= din;
        else if (advance)
            snap <= msb_first ? snap << 1 : snap >> 1;
    end

    assign dout = msb_first ? snap[N-1] : snap[0];
endmodule

// File: rtl/reg_readback_serializer.sv
// reg_readback_serializer: snapshot {rd_q2, rd_q1} on request and send it bit-serially over valid/ready; REG_READBACK_PARITY_EN appends an even-parity bit
module reg_readback_serializer
    import reg_readback_pkg::*;
#(
    parameter int W1        = W1_DEF,
    parameter int W2        = W2_DEF,
    parameter bit MSB_FIRST = 1'b0
) (
    input logic                      clk,
    input logic                      reset,
    reg_readback_serializer_if.slave bus
);
    localparam int N = W1 + W2;
`ifdef REG_READBACK_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    localparam int F  = frame_len(W1, W2, PAR);
    localparam int CW = $clog2(N + 1);

    state_t        state;
    logic [CW-1:0] cnt;
    logic          valid, last, busy, done;
    logic          data_bit, load, advance;

    assign load    = state == IDLE && bus.rd_req;
    assign advance = state == SHIFT && bus.ser_ready;

    reg_readback_shifter #(.N(N)) u_shift (
        .clk       (clk),
        .reset     (reset),
        .load      (load),
        .advance   (advance),
        .msb_first (MSB_FIRST),
        .din       ({bus.rd_q2, bus.rd_q1}),
        .dout      (data_bit)
    );

`ifdef REG_READBACK_PARITY_EN
    logic par_q;

    // parity of the snapshot, taken from the same values that are loaded
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            par_q <= 1'b0;
        else if (load)
            par_q <= ^{bus.rd_q2, bus.rd_q1};
    end

    assign bus.ser_data = valid & (cnt == CW'(N) ? par_q : data_bit);
`else
    assign bus.ser_data = valid & data_bit;
`endif

    // frame sequencer: IDLE -> SHIFT (one bit per handshake) -> DONE pulse -> IDLE
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            valid <= 1'b0;
            last  <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.rd_req) begin
                    state <= SHIFT;
                    cnt   <= '0;
                    valid <= 1'b1;
                    last  <= F == 1;
                    busy  <= 1'b1;
                end
                SHIFT: if (bus.ser_ready) begin
                    if (cnt == CW'(F - 1)) begin
                        state <= DONE;
                        valid <= 1'b0;
                        last  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        cnt  <= cnt + 1'b1;
                        last <= cnt == CW'(F - 2);
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.ser_valid = valid;
    assign bus.ser_last  = last;
    assign bus.busy      = busy;
    assign bus.done      = done;
endmodule

// File: tb/tb_reg_readback_serializer.sv
// tb_reg_readback_serializer: LSB-first and MSB-first instances driven in lockstep, checked cycle by cycle
module tb_reg_readback_serializer;
`ifdef REG_READBACK_PARITY_EN
    localparam int F = 7;
`else
    localparam int F = 6;
`endif

    typedef struct {
        logic [3:0] q1;
        logic [1:0] q2;
        int         stall_at;
        int         stall_len;
        int         req_at;
        int         mut_at;
        logic [5:0] exp_lsb;
        logic [5:0] exp_msb;
        logic       exp_par;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       cur_req = 1'b0;
    logic [3:0] cur_q1 = '0;
    logic [1:0] cur_q2 = '0;
    logic       cur_rdy = 1'b1;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    reg_readback_serializer_if #(.W1(4), .W2(2)) b0 ();
    reg_readback_serializer_if #(.W1(4), .W2(2)) b1 ();

    assign b0.rd_req = cur_req;
    assign b0.rd_q1 = cur_q1;
    assign b0.rd_q2 = cur_q2;
    assign b0.ser_ready = cur_rdy;
    assign b1.rd_req = cur_req;
    assign b1.rd_q1 = cur_q1;
    assign b1.rd_q2 = cur_q2;
    assign b1.ser_ready = cur_rdy;

    reg_readback_serializer #(.W1(4), .W2(2), .MSB_FIRST(1'b0)) u0 (.clk(clk), .reset(reset), .bus(b0));
    reg_readback_serializer #(.W1(4), .W2(2), .MSB_FIRST(1'b1)) u1 (.clk(clk), .reset(reset), .bus(b1));

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%b required=%b", name, act, exp);
        end
    endtask

    task automatic outs(input string t, input logic v, input logic d0, input logic d1,
                        input logic l, input logic bz, input logic dn);
        chk({t, " lsb valid"}, b0.ser_valid, v);
        chk({t, " lsb data"},  b0.ser_data,  d0);
        chk({t, " lsb last"},  b0.ser_last,  l);
        chk({t, " lsb busy"},  b0.busy,      bz);
        chk({t, " lsb done"},  b0.done,      dn);
        chk({t, " msb valid"}, b1.ser_valid, v);
        chk({t, " msb data"},  b1.ser_data,  d1);
        chk({t, " msb last"},  b1.ser_last,  l);
        chk({t, " msb busy"},  b1.busy,      bz);
        chk({t, " msb done"},  b1.done,      dn);
    endtask

    // bit i of the transmitted sequence, parity bit (even) at position 6
    function automatic logic [6:0] ref_seq(input logic [5:0] snap, input bit msb);
        logic [6:0] s;
        for (int i = 0; i < 6; i++) s[i] = snap[msb ? 5 - i : i];
        s[6] = ^snap;
        return s;
    endfunction

    task automatic run(input string tag, input vec_t v, input logic [6:0] s0, input logic [6:0] s1);
        int i = 0;
        int st = 0;
        @(negedge clk);
        cur_q1 = v.q1;
        cur_q2 = v.q2;
        cur_req = 1'b1;
        cur_rdy = 1'b1;
        @(negedge clk);
        cur_req = 1'b0;
        while (i < F) begin
            outs($sformatf("%s bit%0d", tag, i), 1'b1, s0[i], s1[i], i == F - 1, 1'b1, 1'b0);
            cur_req = i == v.req_at;
            if (i == v.mut_at) begin
                cur_q1 = 4'b0000;
                cur_q2 = 2'b00;
            end
            if (i == v.stall_at && st < v.stall_len) begin
                cur_rdy = 1'b0;
                st++;
            end else begin
                cur_rdy = 1'b1;
                i++;
            end
            @(negedge clk);
        end
        cur_req = 1'b0;
        cur_rdy = 1'($urandom);
        outs({tag, " done"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        outs({tag, " idle"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        outs({tag, " noframe"}, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        vec_t vt[5];
        vec_t ones;
        vec_t r;
        logic [6:0] s0, s1;
        vt[0] = '{4'b1011, 2'b10, -1, 0, -1, -1, 6'b101011, 6'b110101, 1'b0};
        vt[1] = '{4'b1011, 2'b10,  2, 3, -1, -1, 6'b101011, 6'b110101, 1'b0};
        vt[2] = '{4'b1011, 2'b10, -1, 0,  3,  2, 6'b101011, 6'b110101, 1'b0};
        vt[3] = '{4'b0001, 2'b00, -1, 0, -1, -1, 6'b000001, 6'b100000, 1'b1};
        vt[4] = '{4'b0110, 2'b01,  5, 2, -1, -1, 6'b010110, 6'b011010, 1'b1};
        ones  = '{4'b1111, 2'b11, -1, 0, -1, -1, 6'b111111, 6'b111111, 1'b0};

        #1 reset = 1'b1;
        #2 outs("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        for (int k = 0; k < 5; k++)
            run($sformatf("vec%0d", k), vt[k], {vt[k].exp_par, vt[k].exp_lsb}, {vt[k].exp_par, vt[k].exp_msb});

        for (int k = 0; k < 8; k++) begin
            r.q1 = 4'($urandom);
            r.q2 = 2'($urandom);
            r.stall_at = $urandom_range(0, F - 1);
            r.stall_len = $urandom_range(0, 3);
            r.req_at = $urandom_range(0, F - 1);
            r.mut_at = $urandom_range(0, F - 1);
            s0 = ref_seq({r.q2, r.q1}, 1'b0);
            s1 = ref_seq({r.q2, r.q1}, 1'b1);
            run($sformatf("rnd%0d", k), r, s0, s1);
        end

        @(negedge clk);
        cur_q1 = 4'b1011;
        cur_q2 = 2'b10;
        cur_req = 1'b1;
        cur_rdy = 1'b1;
        @(negedge clk);
        cur_req = 1'b0;
        repeat (4) @(negedge clk);
        outs("pre-reset bit4", 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
        #2 reset = 1'b1;
        #1 outs("async reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        outs("held reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        reset = 1'b0;
        @(negedge clk);
        outs("after reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        run("ones", ones, {ones.exp_par, ones.exp_lsb}, {ones.exp_par, ones.exp_msb});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
